// File: rtl/config_reg_pkg.sv
// Shared types and default widths for the configuration register bank
// controller and its helpers.
package config_reg_pkg;

   // Controller FSM: one initialisation pass, then normal arbitration.
   typedef enum logic {
      CRB_INIT = 1'b0,
      CRB_RUN  = 1'b1
   } crb_state_e;

   localparam int CRB_DATA_W = 32;
   localparam int CRB_ADDR_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   req        : N request lines
//   grant      : one-hot (or zero) grant, combinational from req
// Search starts at rr_ptr and wraps; after a grant to i, the pointer moves
// to i+1 so i has lowest priority next time. With no grant it holds.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      int idx;
      idx      = 0;
      grant    = '0;
      rr_ptr_d = rr_ptr_q;
      for (int k = 0; k < N; k++) begin
         idx = (int'(rr_ptr_q) + k) % N;
         // first requester found from the pointer wins
         if (grant == '0 && req[idx]) begin
            grant[idx] = 1'b1;
            rr_ptr_d   = PW'((idx + 1) % N);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/config_reg_bank_ctrl.sv
// Controller for a bank of non-reset configuration registers.
// After reset it walks every register writing INIT_VAL, then serves
// read/write requests from NUM_REQ requesters, one access per cycle,
// round-robin.
// Ports:
//   CLK, RST_N        : clock, asynchronous active-low reset
//   req_valid/write   : per-requester request valid and direction
//   req_addr/data     : per-requester address and write data (packed slices)
//   req_ready         : one-hot grant, same cycle as the request
//   rsp_valid/data    : read response, one cycle after the grant
//   reg_en/reg_d_in   : register enables (one-hot) and shared write data
//   reg_q             : current register contents (packed slices)
//   init_done         : high once the init pass has finished
module config_reg_bank_ctrl
   import config_reg_pkg::*;
#(
   parameter int               NUM_REQ  = 2,
   parameter int               NUM_REGS = 8,
   parameter int               DATA_W   = CRB_DATA_W,
   parameter int               ADDR_W   = CRB_ADDR_W,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [DATA_W-1:0]            rsp_data,
   output logic [NUM_REGS-1:0]          reg_en,
   output logic [DATA_W-1:0]            reg_d_in,
   input  logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic                         init_done
);

   crb_state_e          state_q;
   logic [ADDR_W-1:0]   init_cnt_q;
   logic [NUM_REQ-1:0]  rsp_valid_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                init_done_q;

   logic [NUM_REQ-1:0]  arb_req, grant;
   logic                gnt_any, gnt_wr;
   logic [ADDR_W-1:0]   gnt_addr;
   logic [DATA_W-1:0]   gnt_data, rd_data;
   logic [NUM_REGS-1:0] reg_en_c;

   // Requests are invisible to the arbiter until the init pass is done, so
   // the round-robin pointer starts fresh at requester 0 in RUN.
   assign arb_req = (state_q == CRB_RUN) ? req_valid : '0;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .CLK   (CLK),
      .RST_N (RST_N),
      .req   (arb_req),
      .grant (grant)
   );

   // Select the granted requester's fields.
   always_comb begin
      gnt_any  = |grant;
      gnt_wr   = 1'b0;
      gnt_addr = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            gnt_wr   = req_write[i];
            gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
            gnt_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Read mux; an address past the bank matches nothing and reads as 0.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (int'(gnt_addr) == k) rd_data = reg_q[k*DATA_W +: DATA_W];
      end
   end

   // Register enables: walking one-hot during INIT, address decode for a
   // granted in-range write in RUN. Out-of-range writes decode to nothing.
   always_comb begin
      reg_en_c = '0;
      reg_d_in = INIT_VAL;
      if (state_q == CRB_INIT) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(init_cnt_q) == k) reg_en_c[k] = 1'b1;
         end
      end else if (gnt_any && gnt_wr) begin
         reg_d_in = gnt_data;
         for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(gnt_addr) == k) reg_en_c[k] = 1'b1;
         end
      end
   end

   // Registers have no reset, so nothing may be enabled while reset is held.
   assign reg_en    = RST_N ? reg_en_c : '0;
   assign req_ready = RST_N ? grant : '0;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= CRB_INIT;
         init_cnt_q  <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            CRB_INIT: begin
               rsp_valid_q <= '0;
               init_cnt_q  <= init_cnt_q + 1'b1;
               if (int'(init_cnt_q) == NUM_REGS - 1) begin
                  state_q     <= CRB_RUN;
                  init_done_q <= 1'b1;
               end
            end
            CRB_RUN: begin
               // grant is one-hot, so it doubles as the response target
               rsp_valid_q <= (gnt_any && !gnt_wr) ? grant : '0;
               if (gnt_any && !gnt_wr) rsp_data_q <= rd_data;
            end
            default: state_q <= CRB_INIT;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_config_reg_bank_ctrl.sv
// Directed bench for config_reg_bank_ctrl: a default 8-register instance and
// a 6-register instance for out-of-range addressing, each with a behavioural
// register bank attached.
module tb_config_reg_bank_ctrl;

   logic         CLK = 1'b0;
   logic         RST_N;
   int           total = 0;
   int           bad   = 0;

   // 8-register instance
   logic [1:0]   req_valid, req_write, req_ready, rsp_valid;
   logic [5:0]   req_addr;
   logic [63:0]  req_data;
   logic [31:0]  rsp_data, reg_d_in;
   logic [7:0]   reg_en;
   logic [255:0] reg_q;
   logic         init_done;
   logic [31:0]  regs [8];

   // 6-register instance
   logic [1:0]   v6, w6, rdy6, rv6;
   logic [5:0]   a6;
   logic [63:0]  d6;
   logic [31:0]  rd6, din6;
   logic [5:0]   en6;
   logic [191:0] q6;
   logic         done6;
   logic [31:0]  regs6 [6];

   always #5 CLK = ~CLK;

   config_reg_bank_ctrl dut (
      .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .reg_en(reg_en),
      .reg_d_in(reg_d_in), .reg_q(reg_q), .init_done(init_done)
   );

   config_reg_bank_ctrl #(.NUM_REGS(6)) dut6 (
      .CLK(CLK), .RST_N(RST_N), .req_valid(v6), .req_write(w6),
      .req_addr(a6), .req_data(d6), .req_ready(rdy6),
      .rsp_valid(rv6), .rsp_data(rd6), .reg_en(en6),
      .reg_d_in(din6), .reg_q(q6), .init_done(done6)
   );

   // Behavioural register banks (no reset).
   always @(posedge CLK) begin
      for (int k = 0; k < 8; k++) if (reg_en[k]) regs[k] <= reg_d_in;
      for (int k = 0; k < 6; k++) if (en6[k]) regs6[k] <= din6;
   end
   always_comb begin
      reg_q = '0;
      for (int k = 0; k < 8; k++) reg_q[k*32 +: 32] = regs[k];
   end
   always_comb begin
      q6 = '0;
      for (int k = 0; k < 6; k++) q6[k*32 +: 32] = regs6[k];
   end

   task automatic test_reset;
      RST_N = 1'b0; req_valid = 2'b11; req_write = 2'b00; req_addr = '0; req_data = '0;
      v6 = 2'b00; w6 = 2'b00; a6 = '0; d6 = '0;
      @(negedge CLK); @(negedge CLK);
      #1;
      total++; if (reg_en !== 8'h00) begin bad++; $display("FAIL rst_reg_en got=%h exp=00", reg_en); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
      total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
      total++; if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin bad++; $display("FAIL rst_rsp got=%b/%h exp=00/0", rsp_valid, rsp_data); end
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_init;
      logic [7:0] exp;
      for (int c = 0; c < 8; c++) begin
         exp = 8'h01 << c;
         #1;
         total++; if (reg_en !== exp) begin bad++; $display("FAIL init_walk c=%0d got=%h exp=%h", c, reg_en, exp); end
         total++; if (reg_d_in !== 32'h0) begin bad++; $display("FAIL init_data c=%0d got=%h exp=0", c, reg_d_in); end
         total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL init_ready c=%0d got=%b exp=00", c, req_ready); end
         total++; if (init_done !== 1'b0) begin bad++; $display("FAIL init_done_early c=%0d got=%b exp=0", c, init_done); end
         @(negedge CLK);
      end
      req_valid = 2'b00;
      #1;
      total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_done got=%b exp=1", init_done); end
      total++; if (done6 !== 1'b1) begin bad++; $display("FAIL init_done6 got=%b exp=1", done6); end
      total++; if (reg_en !== 8'h00) begin bad++; $display("FAIL run_idle_en got=%h exp=00", reg_en); end
      @(negedge CLK);
   endtask

   task automatic test_round_robin;
      logic [1:0] exp, prev;
      prev = 2'b00;
      req_valid = 2'b11; req_write = 2'b00; req_addr = '0;
      for (int c = 0; c < 6; c++) begin
         exp = (c % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         total++; if (req_ready !== exp) begin bad++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp); end
         if (c > 0) begin
            total++; if (rsp_valid !== prev) begin bad++; $display("FAIL rr_rsp c=%0d got=%b exp=%b", c, rsp_valid, prev); end
         end
         prev = exp;
         @(negedge CLK);
      end
      req_valid = 2'b00;
      #1;
      total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL rr_last_rsp got=%b exp=10", rsp_valid); end
      @(negedge CLK);
   endtask

   task automatic test_write_read;
      req_valid = 2'b01; req_write = 2'b01; req_addr = 6'o03; req_data = {32'h0, 32'hDEADBEEF};
      #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_grant got=%b exp=01", req_ready); end
      total++; if (reg_en !== 8'h08) begin bad++; $display("FAIL wr_en got=%h exp=08", reg_en); end
      total++; if (reg_d_in !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got=%h exp=deadbeef", reg_d_in); end
      @(negedge CLK);
      req_write = 2'b00;
      #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rd_grant got=%b exp=01", req_ready); end
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_no_rsp got=%b exp=00", rsp_valid); end
      @(negedge CLK);
      req_valid = 2'b00;
      #1;
      total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL raw_rsp_valid got=%b exp=01", rsp_valid); end
      total++; if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_rsp_data got=%h exp=deadbeef", rsp_data); end
      @(negedge CLK);
      #1;
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rsp_pulse got=%b exp=00", rsp_valid); end
      total++; if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rsp_hold got=%h exp=deadbeef", rsp_data); end
      @(negedge CLK);
   endtask

   task automatic test_req1_read_then_write;
      req_valid = 2'b10; req_write = 2'b00; req_addr = 6'o70;
      #1;
      total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL r1_grant got=%b exp=10", req_ready); end
      @(negedge CLK);
      req_valid = 2'b01; req_write = 2'b01; req_addr = 6'o07; req_data = {32'h0, 32'h5};
      #1;
      total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL r1_rsp_valid got=%b exp=10", rsp_valid); end
      total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL r1_rsp_init got=%h exp=0", rsp_data); end
      total++; if (req_ready !== 2'b01 || reg_en !== 8'h80) begin bad++; $display("FAIL w7 got=%b/%h exp=01/80", req_ready, reg_en); end
      @(negedge CLK);
      req_valid = 2'b10; req_write = 2'b00; req_addr = 6'o70;
      #1;
      total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL r1b_grant got=%b exp=10", req_ready); end
      @(negedge CLK);
      req_valid = 2'b00;
      #1;
      total++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h5) begin bad++; $display("FAIL r7_new got=%b/%h exp=10/5", rsp_valid, rsp_data); end
      @(negedge CLK);
   endtask

   task automatic test_out_of_range;
      v6 = 2'b01; w6 = 2'b01; a6 = 6'o05; d6 = {32'h0, 32'h1234};
      #1;
      total++; if (rdy6 !== 2'b01 || en6 !== 6'b100000) begin bad++; $display("FAIL oor_w5 got=%b/%b exp=01/100000", rdy6, en6); end
      @(negedge CLK);
      v6 = 2'b10; w6 = 2'b00; a6 = 6'o50;
      #1;
      total++; if (rdy6 !== 2'b10) begin bad++; $display("FAIL oor_r5_grant got=%b exp=10", rdy6); end
      @(negedge CLK);
      v6 = 2'b01; w6 = 2'b01; a6 = 6'o06; d6 = {32'h0, 32'hABCD};
      #1;
      total++; if (rv6 !== 2'b10 || rd6 !== 32'h1234) begin bad++; $display("FAIL oor_r5_rsp got=%b/%h exp=10/1234", rv6, rd6); end
      total++; if (rdy6 !== 2'b01) begin bad++; $display("FAIL oor_w6_grant got=%b exp=01", rdy6); end
      total++; if (en6 !== 6'b000000) begin bad++; $display("FAIL oor_w6_en got=%b exp=000000", en6); end
      @(negedge CLK);
      v6 = 2'b10; w6 = 2'b00; a6 = 6'o70;
      #1;
      total++; if (rdy6 !== 2'b10) begin bad++; $display("FAIL oor_r7_grant got=%b exp=10", rdy6); end
      @(negedge CLK);
      v6 = 2'b00;
      #1;
      total++; if (rv6 !== 2'b10) begin bad++; $display("FAIL oor_r7_valid got=%b exp=10", rv6); end
      total++; if (rd6 !== 32'h0) begin bad++; $display("FAIL oor_r7_data got=%h exp=0", rd6); end
      for (int k = 0; k < 6; k++) begin
         total++;
         if (regs6[k] !== ((k == 5) ? 32'h1234 : 32'h0)) begin
            bad++; $display("FAIL oor_bank k=%0d got=%h", k, regs6[k]);
         end
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_run;
      req_valid = 2'b01; req_write = 2'b00; req_addr = 6'o03;
      #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_grant got=%b exp=01", req_ready); end
      #2;
      RST_N = 1'b0; req_valid = 2'b00;
      #1;
      total++; if (init_done !== 1'b0) begin bad++; $display("FAIL mid_done_drop got=%b exp=0", init_done); end
      total++; if (reg_en !== 8'h00 || req_ready !== 2'b00) begin bad++; $display("FAIL mid_rst_out got=%h/%b exp=00/00", reg_en, req_ready); end
      @(negedge CLK);
      #1;
      total++; if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin bad++; $display("FAIL mid_no_rsp got=%b/%h exp=00/0", rsp_valid, rsp_data); end
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      total++; if (reg_en !== 8'h01) begin bad++; $display("FAIL mid_restart0 got=%h exp=01", reg_en); end
      @(negedge CLK);
      #1;
      total++; if (reg_en !== 8'h02 || init_done !== 1'b0) begin bad++; $display("FAIL mid_restart1 got=%h/%b exp=02/0", reg_en, init_done); end
      @(negedge CLK);
   endtask

   initial begin
      test_reset;
      test_init;
      test_round_robin;
      test_write_read;
      test_req1_read_then_write;
      test_out_of_range;
      test_reset_mid_run;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
